// File: rtl/w2m_pkg.sv
// Shared mem_if definitions for the Wishbone <-> mem_if bridges: field widths,
// request/response layouts, command and response-code encodings, tid layout.
package w2m_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MASK_W  = 4;
    localparam int ID_W    = 4;
    localparam int SEQ_W   = 8;
    localparam int CMD_W   = 3;
    localparam int RCODE_W = 3;

    localparam logic [CMD_W-1:0]   CMD_READ  = 3'b000;
    localparam logic [CMD_W-1:0]   CMD_WRITE = 3'b001;
    localparam logic [RCODE_W-1:0] RCODE_OK  = 3'b000;

    typedef struct packed {
        logic [ID_W-1:0]  rid;
        logic [ID_W-1:0]  srcid;
        logic [SEQ_W-1:0] seq;
    } tid_t;

    // 87 bits: {tid, cmd, mask, data, addr}
    typedef struct packed {
        tid_t              tid;
        logic [CMD_W-1:0]  cmd;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } mem_req_t;

    // 51 bits: {tid, rcode, data}
    typedef struct packed {
        tid_t               tid;
        logic [RCODE_W-1:0] rcode;
        logic [DATA_W-1:0]  data;
    } mem_resp_t;

    function automatic tid_t make_tid(
        input logic [ID_W-1:0]  rid,
        input logic [ID_W-1:0]  srcid,
        input logic [SEQ_W-1:0] seq
    );
        tid_t t;
        t.rid   = rid;
        t.srcid = srcid;
        t.seq   = seq;
        return t;
    endfunction

endpackage

// File: rtl/w2m_bridge_if.sv
// Bus bundles seen by the bridge: a Wishbone classic port and a mem_if
// request/response port, each with master and slave views.
interface w2m_wb_if;
    import w2m_pkg::*;

    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [ADDR_W-1:0] wb_addr_i;
    logic [DATA_W-1:0] wb_data_i;
    logic [MASK_W-1:0] wb_sel_i;
    logic              wb_ack_o;
    logic              wb_err_o;
    logic [DATA_W-1:0] wb_data_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
        output wb_ack_o, wb_err_o, wb_data_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i, wb_sel_i,
        input  wb_ack_o, wb_err_o, wb_data_o
    );
endinterface

interface w2m_mem_if;
    import w2m_pkg::*;

    logic      mem_if_req_valid;
    logic      mem_if_req_ready;
    mem_req_t  mem_if_req;
    logic      mem_if_resp_valid;
    logic      mem_if_resp_ready;
    mem_resp_t mem_if_resp;

    modport master (
        output mem_if_req_valid, mem_if_req, mem_if_resp_ready,
        input  mem_if_req_ready, mem_if_resp_valid, mem_if_resp
    );

    modport slave (
        input  mem_if_req_valid, mem_if_req, mem_if_resp_ready,
        output mem_if_req_ready, mem_if_resp_valid, mem_if_resp
    );
endinterface

// File: rtl/w2m_timeout_cnt.sv
// Response-wait counter: cleared on load, counts while enabled, flags expiry
// once TIMEOUT cycles have elapsed. TIMEOUT of 0 never expires.
module w2m_timeout_cnt #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);
    localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] r_count;
    logic          w_at_limit;

    assign w_at_limit = (r_count == LIMIT);
    assign o_expire   = (TIMEOUT != 0) && w_at_limit;

    // Saturates at the limit so the flag stays up until the next load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && !w_at_limit) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/w2m_bridge.sv
// Wishbone classic slave to mem_if master: one outstanding request, each
// Wishbone cycle becomes one tagged mem_if request terminated by ack or err.
module w2m_bridge
    import w2m_pkg::*;
#(
    parameter int         BUS_WIDTH = 32,
    parameter int         BUS_MASK  = 4,
    parameter logic [3:0] SRC_ID    = 4'h0,
    parameter logic [3:0] RID       = 4'h0,
    parameter int         TIMEOUT   = 1024
) (
    input  logic      clk_i,
    input  logic      rst_i,
    w2m_wb_if.slave   wb,
    w2m_mem_if.master mem
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_RESP  = 3'd2;
    localparam logic [2:0] ST_TERM  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]           r_state;
    logic [SEQ_W-1:0]     r_seq;
    mem_req_t             r_req;
    logic                 r_req_valid;
    logic                 r_resp_ready;
    logic                 r_ack;
    logic                 r_err;
    logic                 r_abort;
    logic [BUS_WIDTH-1:0] r_wb_data;

    logic [BUS_MASK-1:0]  w_sel;
    logic                 w_req_fire;
    logic                 w_resp_match;
    logic                 w_resp_ok;
    logic                 w_expire;
    logic                 w_timeout;
    logic                 w_done;
    logic                 w_cyc_lost;
    logic                 w_wait_en;

    assign w_sel        = wb.wb_sel_i;
    assign w_req_fire   = (r_state == ST_REQ) && r_req_valid && mem.mem_if_req_ready;
    assign w_resp_match = (r_state == ST_RESP) && r_resp_ready && mem.mem_if_resp_valid
                          && (mem.mem_if_resp.tid == r_req.tid);
    assign w_resp_ok    = (mem.mem_if_resp.rcode == RCODE_OK);
    // A response landing on the expiry cycle takes priority over the timeout.
    assign w_timeout    = (r_state == ST_RESP) && w_expire && !w_resp_match;
    assign w_done       = w_resp_match || w_timeout;
    assign w_cyc_lost   = r_abort || !wb.wb_cyc_i;
    assign w_wait_en    = (r_state == ST_RESP);

    w2m_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_load   (w_req_fire),
        .i_en     (w_wait_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_seq        <= '0;
            r_req        <= '0;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b1;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_abort      <= 1'b0;
            r_wb_data    <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Stray responses are accepted here and dropped.
                    if (wb.wb_cyc_i && wb.wb_stb_i) begin
                        r_req.tid    <= make_tid(RID, SRC_ID, r_seq);
                        r_req.cmd    <= wb.wb_we_i ? CMD_WRITE : CMD_READ;
                        r_req.mask   <= w_sel;
                        r_req.data   <= wb.wb_data_i;
                        r_req.addr   <= wb.wb_addr_i;
                        r_req_valid  <= 1'b1;
                        r_resp_ready <= 1'b0;
                        r_abort      <= 1'b0;
                        r_state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!wb.wb_cyc_i) begin
                        r_abort <= 1'b1;
                    end
                    if (w_req_fire) begin
                        r_req_valid  <= 1'b0;
                        r_resp_ready <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (!wb.wb_cyc_i) begin
                        r_abort <= 1'b1;
                    end
                    if (w_done) begin
                        if (w_cyc_lost) begin
                            // Master walked away: finish silently, keep the tag moving.
                            r_seq   <= r_seq + 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ack        <= w_resp_match && w_resp_ok;
                            r_err        <= w_timeout || !w_resp_ok;
                            r_wb_data    <= (w_resp_match && (r_req.cmd == CMD_READ))
                                            ? mem.mem_if_resp.data : '0;
                            r_resp_ready <= 1'b0;
                            r_state      <= ST_TERM;
                        end
                    end
                end
                ST_TERM: begin
                    r_seq        <= r_seq + 1'b1;
                    r_resp_ready <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                ST_DRAIN: begin
                    r_resp_ready <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_req_valid  <= 1'b0;
                    r_resp_ready <= 1'b1;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb.wb_ack_o           = r_ack;
    assign wb.wb_err_o           = r_err;
    assign wb.wb_data_o          = r_wb_data;
    assign mem.mem_if_req_valid  = r_req_valid;
    assign mem.mem_if_req        = r_req;
    assign mem.mem_if_resp_ready = r_resp_ready;

endmodule

// File: tb/tb_w2m_bridge.sv
// Self-checking bench for w2m_bridge: directed vector table, hand-written
// multi-cycle sequences and randomized transactions against a transaction model.
module tb_w2m_bridge;
    import w2m_pkg::*;

    localparam int         TO    = 16;
    localparam logic [3:0] SRC_P = 4'h0;
    localparam logic [3:0] RID_P = 4'h0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          stall;
        int          rdelay;
        logic        stray;
        int          drop;
        logic [2:0]  rcode;
        logic [31:0] rdata;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cur = 0;
    logic [7:0] exp_seq = 8'h00;

    w2m_wb_if  wb_bus ();
    w2m_mem_if mem_bus ();

    w2m_bridge #(
        .BUS_WIDTH (32),
        .BUS_MASK  (4),
        .SRC_ID    (SRC_P),
        .RID       (RID_P),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (wb_bus),
        .mem   (mem_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish, expected finish before 5ms");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, cur, act, exp);
        end
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_ack"}, wb_bus.wb_ack_o, 0);
        chk({name, "_err"}, wb_bus.wb_err_o, 0);
        chk({name, "_wbdata"}, wb_bus.wb_data_o, 0);
        chk({name, "_reqvalid"}, mem_bus.mem_if_req_valid, 0);
        chk({name, "_req"}, mem_bus.mem_if_req, 0);
        chk({name, "_respready"}, mem_bus.mem_if_resp_ready, 1);
    endtask

    function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] sel,
                                int stall, int rdelay, logic stray, int drop, logic [2:0] rcode,
                                logic [31:0] rdata, logic ea, logic ee, logic [31:0] ed);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel;
        v.stall = stall; v.rdelay = rdelay; v.stray = stray; v.drop = drop;
        v.rcode = rcode; v.rdata = rdata;
        v.exp_ack = ea; v.exp_err = ee; v.exp_data = ed;
        return v;
    endfunction

    // Transaction-level outcome: abandoned cycles terminate silently, a missing
    // response is an error with no data, otherwise rcode decides and reads return data.
    function automatic vec_t with_expect(input vec_t t);
        vec_t r = t;
        if (t.drop != 0) begin
            r.exp_ack = 1'b0; r.exp_err = 1'b0; r.exp_data = 32'h0;
        end else if (t.rdelay < 0) begin
            r.exp_ack = 1'b0; r.exp_err = 1'b1; r.exp_data = 32'h0;
        end else begin
            r.exp_ack  = (t.rcode == 3'b000);
            r.exp_err  = (t.rcode != 3'b000);
            r.exp_data = t.we ? 32'h0 : t.rdata;
        end
        return r;
    endfunction

    // Plays both the Wishbone master and the mem_if target for one transaction.
    task automatic run_txn(input vec_t v);
        mem_req_t  exp_req;
        mem_resp_t rsp;
        int        n;
        exp_req.tid  = {RID_P, SRC_P, exp_seq};
        exp_req.cmd  = v.we ? 3'b001 : 3'b000;
        exp_req.mask = v.sel;
        exp_req.data = v.wdata;
        exp_req.addr = v.addr;

        wb_bus.wb_we_i   = v.we;
        wb_bus.wb_addr_i = v.addr;
        wb_bus.wb_data_i = v.wdata;
        wb_bus.wb_sel_i  = v.sel;
        wb_bus.wb_cyc_i  = 1'b1;
        wb_bus.wb_stb_i  = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!mem_bus.mem_if_req_valid && n < 8);
        chk("req_latency", n, 1);
        chk("req_fields", mem_bus.mem_if_req, exp_req);
        if (v.drop == 1) begin
            wb_bus.wb_cyc_i = 1'b0;
            wb_bus.wb_stb_i = 1'b0;
        end
        for (int i = 0; i < v.stall; i++) begin
            step();
            chk("req_hold", {mem_bus.mem_if_req_valid, mem_bus.mem_if_req}, {1'b1, exp_req});
        end
        mem_bus.mem_if_req_ready = 1'b1;
        step();
        mem_bus.mem_if_req_ready = 1'b0;
        chk("req_handshake", mem_bus.mem_if_req_valid, 0);
        if (v.drop == 2) begin
            wb_bus.wb_cyc_i = 1'b0;
            wb_bus.wb_stb_i = 1'b0;
        end

        if (v.rdelay < 0) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!(wb_bus.wb_ack_o || wb_bus.wb_err_o) && n < 64);
            chk("timeout_latency", n, TO + 1);
        end else begin
            for (int d = 0; d < v.rdelay; d++) step();
            if (v.stray) begin
                rsp.tid   = exp_req.tid ^ 16'h0080;
                rsp.rcode = 3'b000;
                rsp.data  = 32'hFFFF_FFFF;
                mem_bus.mem_if_resp       = rsp;
                mem_bus.mem_if_resp_valid = 1'b1;
                chk("stray_ready", mem_bus.mem_if_resp_ready, 1);
                step();
                mem_bus.mem_if_resp_valid = 1'b0;
                chk("stray_ignored", {wb_bus.wb_ack_o, wb_bus.wb_err_o}, 2'b00);
            end
            rsp.tid   = exp_req.tid;
            rsp.rcode = v.rcode;
            rsp.data  = v.rdata;
            mem_bus.mem_if_resp       = rsp;
            mem_bus.mem_if_resp_valid = 1'b1;
            chk("resp_ready", mem_bus.mem_if_resp_ready, 1);
            step();
            mem_bus.mem_if_resp_valid = 1'b0;
        end

        if (v.drop != 0) begin
            for (int i = 0; i < 3; i++) begin
                chk("abort_silent", {wb_bus.wb_ack_o, wb_bus.wb_err_o}, 2'b00);
                step();
            end
        end else begin
            chk("term", {wb_bus.wb_ack_o, wb_bus.wb_err_o}, {v.exp_ack, v.exp_err});
            chk("term_data", wb_bus.wb_data_o, v.exp_data);
            wb_bus.wb_cyc_i = 1'b0;
            wb_bus.wb_stb_i = 1'b0;
            step();
            chk("term_pulse", {wb_bus.wb_ack_o, wb_bus.wb_err_o}, 2'b00);
        end
        exp_seq = exp_seq + 8'h01;

        if (v.rdelay < 0 && v.drop == 0) begin
            rsp.tid   = exp_req.tid;
            rsp.rcode = 3'b000;
            rsp.data  = 32'h0BAD_0BAD;
            mem_bus.mem_if_resp       = rsp;
            mem_bus.mem_if_resp_valid = 1'b1;
            chk("late_ready", mem_bus.mem_if_resp_ready, 1);
            step();
            mem_bus.mem_if_resp_valid = 1'b0;
            chk("late_discard", {wb_bus.wb_ack_o, wb_bus.wb_err_o}, 2'b00);
        end
        cur++;
    endtask

    vec_t tbl [9];

    initial begin
        vec_t      v;
        mem_req_t  er;
        mem_resp_t rsp;
        int        r;

        wb_bus.wb_cyc_i = 1'b0;  wb_bus.wb_stb_i = 1'b0;  wb_bus.wb_we_i = 1'b0;
        wb_bus.wb_addr_i = '0;   wb_bus.wb_data_i = '0;   wb_bus.wb_sel_i = '0;
        mem_bus.mem_if_req_ready = 1'b0;
        mem_bus.mem_if_resp_valid = 1'b0;
        mem_bus.mem_if_resp = '0;

        tbl[0] = mk(1, 32'h2000_0000, 32'h1234_5678, 4'b0011, 5,  0, 0, 0, 3'b000, 32'hFFFF_FFFF, 1, 0, 32'h0);
        tbl[1] = mk(0, 32'h3000_0004, 32'hA5A5_A5A5, 4'b1111, 0,  2, 0, 0, 3'b010, 32'hCAFE_F00D, 0, 1, 32'hCAFE_F00D);
        tbl[2] = mk(0, 32'h4000_0008, 32'h0000_0000, 4'b1111, 1, -1, 0, 0, 3'b000, 32'h0,         0, 1, 32'h0);
        tbl[3] = mk(0, 32'h4000_000C, 32'h0000_0000, 4'b0101, 0,  1, 1, 0, 3'b000, 32'h1357_9BDF, 1, 0, 32'h1357_9BDF);
        tbl[4] = mk(1, 32'h5000_0010, 32'hDEAD_C0DE, 4'b1000, 2, 16, 0, 0, 3'b000, 32'h0,         1, 0, 32'h0);
        tbl[5] = mk(0, 32'h6000_0014, 32'h0000_0000, 4'b1111, 2,  1, 0, 1, 3'b000, 32'h7777_7777, 0, 0, 32'h0);
        tbl[6] = mk(1, 32'h6000_0018, 32'h4444_4444, 4'b0001, 0,  3, 0, 2, 3'b000, 32'h0,         0, 0, 32'h0);
        tbl[7] = mk(1, 32'h7000_0018, 32'h0F0F_0F0F, 4'b0110, 0,  3, 0, 0, 3'b111, 32'h0,         0, 1, 32'h0);
        tbl[8] = mk(0, 32'h8000_001C, 32'h9999_9999, 4'b0100, 3,  0, 0, 0, 3'b000, 32'h0BAD_C0DE, 1, 0, 32'h0BAD_C0DE);

        // Reset state
        rst = 1'b1;
        step(); step(); step();
        check_reset_state("reset");
        rst = 1'b0;
        step();

        // Minimum latency with ready/valid held high, then a back-to-back cycle on held stb
        mem_bus.mem_if_req_ready  = 1'b1;
        rsp.tid = 16'h0000; rsp.rcode = 3'b000; rsp.data = 32'hDEAD_BEEF;
        mem_bus.mem_if_resp       = rsp;
        mem_bus.mem_if_resp_valid = 1'b1;
        wb_bus.wb_we_i = 1'b0; wb_bus.wb_addr_i = 32'h1000_0040;
        wb_bus.wb_data_i = 32'h1111_1111; wb_bus.wb_sel_i = 4'hF;
        wb_bus.wb_cyc_i = 1'b1; wb_bus.wb_stb_i = 1'b1;
        er.tid = 16'h0000; er.cmd = 3'b000; er.mask = 4'hF; er.data = 32'h1111_1111; er.addr = 32'h1000_0040;
        step();
        chk("minlat_c1_valid", mem_bus.mem_if_req_valid, 1);
        chk("minlat_c1_req", mem_bus.mem_if_req, er);
        step();
        chk("minlat_c2_valid", mem_bus.mem_if_req_valid, 0);
        step();
        chk("minlat_c3_ack", {wb_bus.wb_ack_o, wb_bus.wb_err_o}, 2'b10);
        chk("minlat_c3_data", wb_bus.wb_data_o, 32'hDEAD_BEEF);
        rsp.tid = 16'h0001; rsp.data = 32'h600D_F00D;
        mem_bus.mem_if_resp = rsp;
        step();
        chk("b2b_idle_noack", {wb_bus.wb_ack_o, wb_bus.wb_err_o}, 2'b00);
        step();
        er.tid = 16'h0001;
        chk("b2b_req", {mem_bus.mem_if_req_valid, mem_bus.mem_if_req}, {1'b1, er});
        step();
        step();
        chk("b2b_ack", {wb_bus.wb_ack_o, wb_bus.wb_data_o}, {1'b1, 32'h600D_F00D});
        wb_bus.wb_cyc_i = 1'b0; wb_bus.wb_stb_i = 1'b0;
        mem_bus.mem_if_req_ready = 1'b0; mem_bus.mem_if_resp_valid = 1'b0;
        step();
        exp_seq = 8'h02;

        // Directed vector table
        for (int i = 0; i < 9; i++) run_txn(tbl[i]);

        // Back-to-back reads across the sequence wrap
        for (int i = 0; i < 257; i++) begin
            v = mk(0, $urandom, $urandom, 4'($urandom_range(0, 15)), 0, 0, 0, 0, 3'b000, $urandom, 0, 0, 0);
            run_txn(with_expect(v));
        end

        // Randomized transactions against the outcome model
        for (int k = 0; k < 40; k++) begin
            v.we    = 1'($urandom_range(0, 1));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.sel   = 4'($urandom_range(0, 15));
            v.stall = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            v.rdelay = (r == 0) ? -1 : $urandom_range(0, TO);
            v.drop  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
            if (v.drop != 0) v.rdelay = $urandom_range(0, 8);
            v.stray = (v.rdelay >= 0) && (v.rdelay <= 10) && ($urandom_range(0, 3) == 0);
            v.rcode = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            v.rdata = $urandom;
            run_txn(with_expect(v));
        end

        // Leave known read data on the bus, then reset while waiting for a response
        run_txn(mk(0, 32'h9000_0000, 32'h0, 4'hF, 0, 0, 0, 0, 3'b000, 32'h5555_AAAA, 1, 0, 32'h5555_AAAA));
        wb_bus.wb_we_i = 1'b1; wb_bus.wb_addr_i = 32'hA000_0000;
        wb_bus.wb_data_i = 32'h3333_3333; wb_bus.wb_sel_i = 4'hF;
        wb_bus.wb_cyc_i = 1'b1; wb_bus.wb_stb_i = 1'b1;
        step();
        mem_bus.mem_if_req_ready = 1'b1;
        step();
        mem_bus.mem_if_req_ready = 1'b0;
        rst = 1'b1;
        step();
        check_reset_state("rst_in_resp");
        rst = 1'b0;
        wb_bus.wb_cyc_i = 1'b0; wb_bus.wb_stb_i = 1'b0;
        step();
        chk("rst_no_term", {wb_bus.wb_ack_o, wb_bus.wb_err_o}, 2'b00);
        exp_seq = 8'h00;
        run_txn(mk(0, 32'hB000_0004, 32'h0, 4'b0011, 1, 2, 0, 0, 3'b000, 32'h2468_ACE0, 1, 0, 32'h2468_ACE0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/w2m_bridge.md
# w2m_bridge

Wishbone classic slave to mem_if master bridge, the inverse of the mem_if-to-Wishbone bridge used behind the test IO master. It accepts single Wishbone cycles from a system-side master, converts each into one mem_if request, waits for the matching mem_if response and terminates the Wishbone cycle with ack or err. It sits on the system clock domain in front of any mem_if target (CPU NoC port, SRAM controller) and has one transaction outstanding at a time.

## Interface
- BUS_WIDTH, 32: address/data width (only 32 supported)
- BUS_MASK, 4: byte-select width
- SRC_ID, 4'h0: value driven in the request tid srcid field
- RID, 4'h0: value driven in the request tid rid field
- TIMEOUT, 1024: response-wait cycles before error termination; 0 disables the timeout
- clk_i  in  1  clock
- rst_i  in  1  reset: one clock; reset is synchronous and active-high
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone cycle, strobe, write enable
- wb_addr_i, wb_data_i  in  BUS_WIDTH  address, write data
- wb_sel_i  in  BUS_MASK  byte selects
- wb_ack_o, wb_err_o  out  1  termination pulses
- wb_data_o  out  BUS_WIDTH  read data
- mem_if_req_valid  out  1; mem_if_req_ready  in  1
- mem_if_req  out  87  {tid[15:0], cmd[2:0], mask[3:0], data[31:0], addr[31:0]}; tid = {rid[3:0], srcid[3:0], seq[7:0]}; cmd 3'b000 read, 3'b001 write
- mem_if_resp_valid  in  1; mem_if_resp_ready  out  1
- mem_if_resp  in  51  {tid[15:0], rcode[2:0], data[31:0]}; rcode 3'b000 OK, anything else error

## Operation
- FSM: IDLE, REQ, RESP, TERM, DRAIN.
- IDLE: on wb_cyc_i & wb_stb_i register addr/data/sel/we into the request, -> REQ.
- REQ: mem_if_req_valid=1, request stable; on ready -> RESP, start timeout counter. Valid never drops before the handshake, even if wb_cyc_i falls.
- RESP: mem_if_resp_ready=1. Response with tid equal to the issued tid: capture data and rcode, -> TERM. Response with other tid: accept and discard, stay. Counter reaching TIMEOUT: -> TERM with error.
- TERM: exactly one of wb_ack_o (rcode OK) / wb_err_o (rcode error or timeout) high one cycle; wb_data_o holds captured data (0 on write/timeout); seq += 1 (8-bit wrap 0xFF->0x00); -> IDLE.
- Abort: wb_cyc_i low in REQ or RESP: request still completes; response accepted; no ack/err issued; -> IDLE. If wb_cyc_i is already low when the FSM would enter TERM, go straight to IDLE (seq still increments).
- DRAIN is unused by the timeout path: IDLE keeps mem_if_resp_ready=1 and discards any stray (late) response.
- Write-data on reads and sel on reads are forwarded unchanged.

## Timing
- Reset values: wb_ack_o=0, wb_err_o=0, wb_data_o=0, mem_if_req_valid=0, mem_if_req=0, mem_if_resp_ready=1, seq=0, state IDLE. Reset mid-transaction abandons it immediately; no termination pulse.
- Minimum latency with ready/valid always high: stb seen cycle 0, req_valid cycle 1, response accepted cycle 2, ack cycle 3.
- All outputs registered; no combinational path from any input to any output.
- Timeout: err asserted TIMEOUT+1 cycles after the request handshake.
- Response arriving on the same cycle the counter expires: the response wins (ack/rcode).
- Back-to-back: the cycle after TERM is IDLE; a still-asserted stb starts a new transaction there.

## Structure
- Shared package w2m_pkg: field widths, req/resp packed struct typedefs, cmd and rcode constants, tid layout. The mem_if-to-Wishbone bridge uses the same package.
- One sub-module is natural: w2m_timeout_cnt (load/enable counter with expire flag). Everything else is flat in w2m_bridge.

## Test plan
- Read 0x1000_0040, target returns data 0xDEAD_BEEF rcode 0, ready/valid always high -> req cmd 000 tid 0x0000, wb_ack_o at cycle 3, wb_data_o 0xDEADBEEF.
- Write 0x2000_0000 data 0x1234_5678 sel 4'b0011, ready held low 5 cycles -> req stable during stall, mask 0011, single ack, seq advances to 1.
- Response rcode 3'b010 -> wb_err_o one cycle, no ack.
- TIMEOUT=16, no response -> err 17 cycles after handshake; later response with old tid accepted in IDLE and discarded; next transaction uses seq+1 and acks normally.
- wb_cyc_i dropped while in REQ -> handshake still completes, response drained, no ack/err.
- 257 back-to-back reads -> seq wraps 0xFF->0x00; rst_i asserted in RESP -> all outputs return to reset values next cycle.
